// File: rtl/norm_pkg.sv
// Shared definitions for the partial-sum accumulator and the normalizer:
// default widths and the output-handshake state encoding.
package norm_pkg;

    localparam int unsigned BW       = 8;
    localparam int unsigned BW_PSUM  = 2 * BW + 4;
    localparam int unsigned COL      = 8;
    localparam int unsigned ACCLEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_BUSY = 2'd2
    } norm_state_e;

endpackage

// File: rtl/psum_lane_add.sv
// One signed partial-sum lane adder with overflow detection.
// Build option: PSUM_ACC_SAT_EN clamps an overflowing lane to the most
// positive / most negative value; without it the lane wraps.
module psum_lane_add
    import norm_pkg::*;
#(
    parameter int unsigned W = BW_PSUM
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum,
    output logic                o_ovf
);

    logic signed [W-1:0] w_raw;

    // Add, flag same-sign operands whose result flips sign, optionally clamp.
    always_comb begin
        w_raw = i_a + i_b;
        o_ovf = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);
`ifdef PSUM_ACC_SAT_EN
        if (o_ovf) begin
            o_sum = i_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            o_sum = w_raw;
        end
`else
        o_sum = w_raw;
`endif
    end

endmodule

// File: rtl/psum_acc.sv
// Partial-sum row accumulator: sums acc_len beats lane-wise into an acc
// register set, then hands the finished row to a downstream normalizer
// through an IDLE/HOLD/BUSY level handshake while the next row accumulates.
// Build option: PSUM_ACC_SAT_EN selects saturating lanes (default wraps).
module psum_acc
    import norm_pkg::*;
#(
    parameter int unsigned bw      = BW,
    parameter int unsigned bw_psum = 2 * bw + 4,
    parameter int unsigned col     = COL
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [bw_psum*col-1:0]    in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ACCLEN_W-1:0]       acc_len,
    input  logic                      norm_done,
    output logic [bw_psum*col-1:0]    out,
    output logic                      out_valid,
    output logic                      ovf
);

    logic [ACCLEN_W-1:0]          r_cnt;
    logic [ACCLEN_W-1:0]          r_len_m1;
    logic [col-1:0][bw_psum-1:0]  r_acc;
    logic                         r_full;
    logic [col-1:0][bw_psum-1:0]  r_out;
    logic                         r_ovf;
    norm_state_e                  r_state;

    norm_state_e                  w_state_nxt;
    logic                         w_fire;
    logic                         w_first;
    logic [ACCLEN_W-1:0]          w_len_m1;
    logic                         w_last;
    logic [col-1:0][bw_psum-1:0]  w_sum;
    logic [col-1:0]               w_lane_ovf;
    logic [col-1:0][bw_psum-1:0]  w_row;
    logic                         w_load_acc;
    logic                         w_load_bypass;

    assign in_ready  = ~r_full;
    assign out_valid = (r_state == ST_HOLD);
    assign out       = r_out;
    assign ovf       = r_ovf;

    assign w_fire   = in_valid & in_ready;
    assign w_first  = (r_cnt == '0);
    assign w_len_m1 = w_first ? ((acc_len == '0) ? '0 : acc_len - 1'b1) : r_len_m1;
    assign w_last   = w_fire && (r_cnt == w_len_m1);

    for (genvar k = 0; k < int'(col); k++) begin : g_lane
        psum_lane_add #(.W(bw_psum)) u_add (
            .i_a   (r_acc[k]),
            .i_b   (in[k*bw_psum +: bw_psum]),
            .o_sum (w_sum[k]),
            .o_ovf (w_lane_ovf[k])
        );
    end

    // First beat of a row loads the lanes, later beats take the lane sums.
    always_comb begin
        w_row = '0;
        for (int unsigned k = 0; k < col; k++) begin
            w_row[k] = w_first ? in[k*bw_psum +: bw_psum] : w_sum[k];
        end
    end

    // Beat counter, latched row length and the acc register set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_len_m1 <= '0;
            r_acc    <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_fire) begin
                r_acc <= w_row;
                if (w_first) begin
                    r_len_m1 <= w_len_m1;
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_load_acc) begin
                r_full <= 1'b0;
            end else if (w_last && !w_load_bypass) begin
                r_full <= 1'b1;
            end
        end
    end

    // Sticky overflow: only add beats can overflow, the first beat just loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_fire && !w_first && (|w_lane_ovf)) begin
            r_ovf <= 1'b1;
        end
    end

    // Output handshake next-state. A row finishing while IDLE goes straight to
    // out without parking in acc, which gives the single-cycle latency; acc
    // still takes the row but full stays clear.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_acc    = 1'b0;
        w_load_bypass = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full) begin
                    w_load_acc  = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_last) begin
                    w_load_bypass = 1'b1;
                    w_state_nxt   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!norm_done) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (norm_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and the out row, which changes only on IDLE->HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_acc) begin
                r_out <= r_acc;
            end else if (w_load_bypass) begin
                r_out <= w_row;
            end
        end
    end

endmodule

// File: tb/tb_psum_acc.sv
// Scoreboard bench for psum_acc: stimulus pushes expected rows computed with
// plain integer arithmetic; a monitor pops one row per out_valid rising edge.
module tb_psum_acc;
    import norm_pkg::*;

    localparam int W    = BW_PSUM;
    localparam int C    = COL;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));
    localparam int MODV = 1 << W;

    typedef logic [W*C-1:0] row_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] acc_len = 4'd0;
    row_t       d_in = '0;
    logic       in_ready;
    logic       norm_done;
    row_t       d_out;
    logic       out_valid;
    logic       ovf;

    logic       auto_norm = 1'b0;
    logic       man_nd = 1'b1;
    logic       nd_auto = 1'b1;
    int         nd_cnt = 0;

    assign norm_done = auto_norm ? nd_auto : man_nd;

    always #5 clk = ~clk;

    psum_acc #(.bw(BW), .bw_psum(W), .col(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (d_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_len   (acc_len),
        .norm_done (norm_done),
        .out       (d_out),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    int   n_pass = 0;
    int   n_total = 0;

    row_t exp_q[$];
    int   m_idx = 0;
    int   m_len = 1;
    int   m_acc[C];
    bit   m_ovf = 1'b0;
    int   bv[C];

    task automatic chk(input string nm, input longint act, input longint expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic chk_row(input string nm, input row_t act, input row_t expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // Reference model: a row is acc_len beats (0 means 1) summed lane-wise
    // as ordinary integers, then wrapped or clamped back into W bits.
    task automatic model_beat(input logic [3:0] len);
        int   s;
        row_t r;
        if (m_idx == 0) begin
            m_len = (len == 0) ? 1 : int'(len);
            for (int k = 0; k < C; k++) m_acc[k] = bv[k];
        end else begin
            for (int k = 0; k < C; k++) begin
                s = m_acc[k] + bv[k];
                if (s > MAXV || s < MINV) begin
                    m_ovf = 1'b1;
`ifdef PSUM_ACC_SAT_EN
                    s = (s > MAXV) ? MAXV : MINV;
`else
                    s = (s > MAXV) ? s - MODV : s + MODV;
`endif
                end
                m_acc[k] = s;
            end
        end
        m_idx++;
        if (m_idx == m_len) begin
            for (int k = 0; k < C; k++) r[k*W +: W] = W'(m_acc[k]);
            exp_q.push_back(r);
            m_idx = 0;
        end
    endtask

    // Entered just after a negedge; returns just after the negedge following the transfer.
    task automatic send_beat(input logic [3:0] len);
        int waited = 0;
        for (int k = 0; k < C; k++) d_in[k*W +: W] = W'(bv[k]);
        acc_len  = len;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL beat_accept: in_ready stayed %0b, required 1 within 300 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        model_beat(len);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_idx = 0;
        m_ovf = 1'b0;
    endtask

    task automatic retire();
        man_nd = 1'b0;
        @(negedge clk);
        man_nd = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic int rnd_lane();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, MODV - 1)) - MODV / 2;
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    // Randomized normalizer: after a row is presented, goes busy for a few cycles.
    always @(negedge clk) begin
        if (auto_norm) begin
            if (nd_cnt > 0) begin
                nd_cnt--;
                if (nd_cnt == 0) nd_auto = 1'b1;
            end else if (out_valid && nd_auto && $urandom_range(0, 1) == 1) begin
                nd_auto = 1'b0;
                nd_cnt  = int'($urandom_range(1, 5));
            end
        end
    end

    // Monitor: each out_valid rising edge consumes one expected row; out must
    // then hold that row for as long as out_valid stays high.
    logic prev_ov = 1'b0;
    row_t held = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_row: out_valid rose with no row pending, out=%h", d_out);
                end else begin
                    held = exp_q.pop_front();
                    chk_row("row", d_out, held);
                end
            end else if (out_valid && prev_ov) begin
                chk_row("out_stable", d_out, held);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int   t;
        int   rows_len;
        int   beats;
        logic signed [W-1:0] l0;
        longint exp_l0;

        @(negedge clk);
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk_row("rst_out", d_out, '0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single-beat row of 5s, presented one cycle after the beat.
        for (int k = 0; k < C; k++) bv[k] = 5;
        send_beat(4'd1);
        chk("latency_out_valid", out_valid, 1);
        chk("ovf_clean", ovf, 0);
        retire();

        // Three beats k, k+1, -1 give 2k; out_valid holds until norm_done=0 sampled.
        for (int k = 0; k < C; k++) bv[k] = k;
        send_beat(4'd3);
        for (int k = 0; k < C; k++) bv[k] = k + 1;
        send_beat(4'd3);
        for (int k = 0; k < C; k++) bv[k] = -1;
        send_beat(4'd3);
        repeat (3) @(negedge clk);
        chk("hold_while_idle", out_valid, 1);
        man_nd = 1'b0;
        @(negedge clk);
        chk("drop_after_busy", out_valid, 0);
        man_nd = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back rows while the normalizer stays busy.
        man_nd = 1'b0;
        for (int k = 0; k < C; k++) bv[k] = rnd_lane();
        send_beat(4'd1);
        for (int k = 0; k < C; k++) bv[k] = rnd_lane();
        send_beat(4'd2);
        for (int k = 0; k < C; k++) bv[k] = rnd_lane();
        send_beat(4'd2);
        repeat (20) @(negedge clk);
        chk("full_blocks_input", in_ready, 0);
        chk("row2_waits", out_valid, 0);
        man_nd = 1'b1;
        repeat (3) @(negedge clk);
        chk("row2_presented", out_valid, 1);
        chk("ready_after_copy", in_ready, 1);
        retire();

        // Most-positive lane 0 plus one overflows.
        for (int k = 0; k < C; k++) bv[k] = rnd_lane() % 100;
        bv[0] = MAXV;
        send_beat(4'd2);
        for (int k = 0; k < C; k++) bv[k] = rnd_lane() % 100;
        bv[0] = 1;
        send_beat(4'd2);
        chk("ovf_set", ovf, 1);
        l0 = d_out[W-1:0];
`ifdef PSUM_ACC_SAT_EN
        exp_l0 = 524287;
`else
        exp_l0 = -524288;
`endif
        chk("ovf_lane0", longint'(l0), exp_l0);
        retire();
        chk("ovf_sticky", ovf, 1);

        // Reset during the second beat of a four-beat row discards it.
        for (int k = 0; k < C; k++) bv[k] = 11;
        send_beat(4'd4);
        for (int k = 0; k < C; k++) d_in[k*W +: W] = W'(22);
        in_valid = 1'b1;
        do_reset();
        chk("ovf_cleared", ovf, 0);
        repeat (6) @(negedge clk);
        chk("no_row_after_reset", out_valid, 0);
        for (int k = 0; k < C; k++) bv[k] = 7;
        send_beat(4'd1);
        chk("fresh_row_valid", out_valid, 1);
        retire();

        // acc_len=0 behaves as a single-beat row.
        for (int k = 0; k < C; k++) bv[k] = -3;
        send_beat(4'd0);
        chk("len0_valid", out_valid, 1);
        retire();

        // Randomized rows against a randomly busy normalizer.
        auto_norm = 1'b1;
        for (int r = 0; r < 40; r++) begin
            rows_len = int'($urandom_range(0, 15));
            beats = (rows_len == 0) ? 1 : rows_len;
            for (int b = 0; b < beats; b++) begin
                for (int k = 0; k < C; k++) bv[k] = rnd_lane();
                send_beat(4'(rows_len));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        chk("ovf_random", ovf, m_ovf);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
